err_metric_acc: RTL
===================

ERR_METRIC_ACC -- requirements
Module: err_metric_acc

Interface
REQ-001 SHALL have parameter W, default 16, product width of the multiplier under test.
REQ-002 SHALL have parameter N_SAMPLES, default 10000, samples per measurement run (1..65535).
REQ-003 SHALL have parameter CW, default 16, sample-counter width, ceil(log2(N_SAMPLES+1)) <= CW.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports: clk  in  1  single clock, all state on rising edge.
REQ-006 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-007 Ports: start  in  1  one-cycle pulse, begins a measurement run.
REQ-008 Ports: in_valid  in  1  sample pair present.
REQ-009 Ports: in_ready  out  1  sample accepted when in_valid&in_ready.
REQ-010 Ports: apprx  in  W  approximate multiplier product (dat_o).
REQ-011 Ports: exact  in  W  exact product A*B.
REQ-012 Ports: busy  out  1  run in progress.
REQ-013 Ports: done  out  1  run complete, metrics final and stable.
REQ-014 Ports: sample_cnt  out  CW  samples accepted this run.
REQ-015 Ports: err_cnt  out  CW  samples with apprx != exact.
REQ-016 Ports: sum_ed  out  W+CW+1  signed sum of (exact - apprx), two's complement.
REQ-017 Ports: sum_ed_abs  out  W+CW  unsigned sum of |exact - apprx|.
REQ-018 Ports: max_ed  out  W  largest |exact - apprx| this run.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start; RUN->DRAIN on acceptance of sample N_SAMPLES; DRAIN->DONE when pipeline empty; DONE->RUN on start.
REQ-021 On entering RUN SHALL clear sample_cnt, err_cnt, sum_ed, sum_ed_abs, max_ed to 0 in the same edge.
REQ-022 in_ready SHALL be 1 only in RUN; samples offered in other states SHALL be ignored, not buffered.
REQ-023 start while RUN or DRAIN SHALL be ignored.
REQ-024 Stage 1 SHALL register d = exact - apprx (W+1 signed), |d| (W unsigned) and neq = (apprx != exact) one cycle after acceptance.
REQ-025 Stage 2 SHALL update accumulators one cycle after stage 1; metric latency = 2 cycles from acceptance.
REQ-026 sample_cnt SHALL increment on the acceptance edge; other outputs on stage 2 retirement.
REQ-027 err_cnt SHALL increment only when neq=1; d=0 samples SHALL add 0 to both sums.
REQ-028 max_ed SHALL update only when |d| > max_ed (strictly greater).
REQ-029 Accumulators SHALL not overflow for N_SAMPLES samples at full-scale |d| = 2^W-1; no saturation logic.
REQ-030 done SHALL be 1 only in DONE, asserting the cycle after the last sample retires from stage 2.
REQ-031 busy SHALL be 1 in RUN and DRAIN.
REQ-032 Back-to-back acceptance every cycle SHALL be supported; throughput 1 sample/cycle.
REQ-033 Outputs SHALL hold their values in DONE and IDLE until the next start.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, in_ready=0, busy=0, done=0, all metric outputs and pipeline valids to 0.
REQ-035 Reset mid-run SHALL discard in-flight samples; no partial result SHALL appear after release.
REQ-036 First start SHALL be honoured the first clock edge after rst_n deasserts.

Structure
REQ-037 Package err_metric_pkg SHALL hold the state enum, default W, N_SAMPLES and CW.
REQ-038 Sub-module err_diff_stage SHALL implement stage 1 (difference, absolute value, neq), registered.

Verification
REQ-039 N_SAMPLES=4; start, samples (apprx,exact) = (100,100),(90,100),(110,100),(0,65025) -> err_cnt=3, sum_ed=65025, sum_ed_abs=65045, max_ed=65025, done 2 cycles after 4th acceptance +1.
REQ-040 N_SAMPLES=3, all apprx==exact -> err_cnt=0, sum_ed=0, sum_ed_abs=0, max_ed=0, sample_cnt=3, done=1.
REQ-041 Full-scale: N_SAMPLES=65535, every sample apprx=0, exact=65535 -> sum_ed_abs=65535*65535, no wrap, err_cnt=65535.
REQ-042 in_valid held high in IDLE and DONE -> in_ready=0, sample_cnt unchanged; start in RUN -> counters not cleared.
REQ-043 Assert rst_n=0 after 2 of 4 samples -> all outputs 0 at once; fresh start then yields results of the new run only.
REQ-044 Equal-max: samples |d| = 5,5,3 -> max_ed=5 updated once (strict compare), checked via assertion on update count.

Source files
------------

// File: rtl/err_metric_pkg.sv
// rtl/err_metric_pkg.sv - shared state encoding and default sizing for the error-metric accumulator
package err_metric_pkg;

    localparam int DEF_W         = 16;
    localparam int DEF_N_SAMPLES = 10000;
    localparam int DEF_CW        = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/err_diff_stage.sv
// rtl/err_diff_stage.sv - registered difference, magnitude and mismatch flag for one sample pair
module err_diff_stage
    import err_metric_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vld,
    input  logic [W-1:0]        apprx,
    input  logic [W-1:0]        exact,
    output logic                vld_o,
    output logic signed [W:0]   diff_o,
    output logic [W-1:0]        abs_o,
    output logic                neq_o
);

    logic               vld_d, vld_q;
    logic signed [W:0]  diff_c, diff_d, diff_q;
    logic [W-1:0]       abs_c, abs_d, abs_q;
    logic               neq_d, neq_q;

    always_comb begin
        diff_c = $signed({1'b0, exact}) - $signed({1'b0, apprx});
        // Magnitude of a (W+1)-bit difference of unsigned W-bit values always fits in W bits.
        abs_c  = diff_c[W] ? W'(-diff_c) : diff_c[W-1:0];
        vld_d  = in_vld;
        diff_d = in_vld ? diff_c : diff_q;
        abs_d  = in_vld ? abs_c : abs_q;
        neq_d  = in_vld ? (apprx != exact) : neq_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            diff_q <= '0;
            abs_q  <= '0;
            neq_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            diff_q <= diff_d;
            abs_q  <= abs_d;
            neq_q  <= neq_d;
        end
    end

    assign vld_o  = vld_q;
    assign diff_o = diff_q;
    assign abs_o  = abs_q;
    assign neq_o  = neq_q;

endmodule

// File: rtl/err_metric_acc.sv
// rtl/err_metric_acc.sv - accumulates error metrics of an approximate multiplier over a fixed-length run
module err_metric_acc
    import err_metric_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int CW        = DEF_CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      apprx,
    input  logic [W-1:0]      exact,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     sample_cnt,
    output logic [CW-1:0]     err_cnt,
    output logic [W+CW:0]     sum_ed,
    output logic [W+CW-1:0]   sum_ed_abs,
    output logic [W-1:0]      max_ed
);

    localparam logic [CW-1:0] LAST_CNT = CW'(N_SAMPLES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]      err_cnt_q, err_cnt_d;
    logic [W+CW:0]      sum_ed_q, sum_ed_d;
    logic [W+CW-1:0]    sum_abs_q, sum_abs_d;
    logic [W-1:0]       max_ed_q, max_ed_d;

    logic               accept;
    logic               clear;
    logic               max_upd;
    logic               s1_vld;
    logic signed [W:0]  s1_diff;
    logic [W-1:0]       s1_abs;
    logic               s1_neq;

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;

    err_diff_stage #(.W(W)) u_diff (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (accept),
        .apprx  (apprx),
        .exact  (exact),
        .vld_o  (s1_vld),
        .diff_o (s1_diff),
        .abs_o  (s1_abs),
        .neq_o  (s1_neq)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept && (sample_cnt_q == LAST_CNT)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 1 holds the final sample for one cycle; leave once it has retired.
                if (!s1_vld) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        sum_ed_d     = sum_ed_q;
        sum_abs_d    = sum_abs_q;
        max_ed_d     = max_ed_q;
        max_upd      = s1_vld && (s1_abs > max_ed_q);
        if (clear) begin
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            sum_ed_d     = '0;
            sum_abs_d    = '0;
            max_ed_d     = '0;
        end else begin
            if (accept) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
            end
            if (s1_vld) begin
                err_cnt_d = err_cnt_q + CW'(s1_neq);
                sum_ed_d  = sum_ed_q + {{CW{s1_diff[W]}}, s1_diff};
                sum_abs_d = sum_abs_q + {{CW{1'b0}}, s1_abs};
                if (max_upd) begin
                    max_ed_d = s1_abs;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            sum_ed_q     <= '0;
            sum_abs_q    <= '0;
            max_ed_q     <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            sum_ed_q     <= sum_ed_d;
            sum_abs_q    <= sum_abs_d;
            max_ed_q     <= max_ed_d;
        end
    end

    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = sample_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign sum_ed     = sum_ed_q;
    assign sum_ed_abs = sum_abs_q;
    assign max_ed     = max_ed_q;

endmodule
